serial_layer_scheduler: RTL and testbench

//  Time-multiplexes one bit-serial neuron core across M neurons of a layer.
//  - Holds M weight vectors and one latched input vector.
//  - For each neuron in turn: serialises inputs/weights LSB-first into the core, pulses its start, waits for core_rdy.
//  - Captures each neuron result and emits it on a result stream with its neuron index.

---
 rtl/serial_sched_pkg.sv | 23 ++
 rtl/serial_lane_feeder.sv | 37 +++
 rtl/serial_layer_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_serial_layer_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sched_pkg.sv
// Shared types and helpers for the serial layer scheduler.
// The optional WAIT watchdog is enabled by defining SERIAL_SCHED_TIMEOUT_EN.
package serial_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_WAIT,
        ST_DONE
    } sched_state_t;

    // Watchdog expires after this many WIDTH-periods in WAIT without core_rdy.
    localparam int WDOG_MULT = 4;

    function automatic int clog2_min1(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/serial_lane_feeder.sv
// N parallel-in / serial-out lanes, LSB first; arithmetic shift keeps the
// sign bit in place so the lanes sign-extend once the word is exhausted.
module serial_lane_feeder #(
    parameter int N     = 2,
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               shift_i,
    input  logic               hold_sign_i,
    input  logic [N*WIDTH-1:0] par_i,
    output logic [N-1:0]       bit_o
);

    logic [N*WIDTH-1:0] sreg_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg_q <= '0;
        end else if (load_i) begin
            sreg_q <= par_i;
        end else if (shift_i) begin
            for (int k = 0; k < N; k++) begin
                sreg_q[k*WIDTH +: WIDTH] <= $signed(sreg_q[k*WIDTH +: WIDTH]) >>> 1;
            end
        end
    end

    always_comb begin
        bit_o = '0;
        for (int k = 0; k < N; k++) begin
            bit_o[k] = hold_sign_i ? sreg_q[k*WIDTH + WIDTH-1] : sreg_q[k*WIDTH];
        end
    end

endmodule

// File: rtl/serial_layer_scheduler.sv
// Sequences M neurons of a layer through one shared bit-serial neuron core.
// Define SERIAL_SCHED_TIMEOUT_EN to add a WAIT watchdog that emits a zero result.
module serial_layer_scheduler
    import serial_sched_pkg::*;
#(
    parameter int N     = 2,
    parameter int M     = 4,
    parameter int WIDTH = 8,
    parameter int OUT_W = 8,
    parameter int IDX_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               w_we,
    input  logic [IDX_W-1:0]   w_addr,
    input  logic [N*WIDTH-1:0] w_data,
    input  logic               layer_start,
    input  logic [N*WIDTH-1:0] in_vec,
    output logic               core_start,
    output logic [N-1:0]       core_inp,
    output logic [N-1:0]       core_w,
    input  logic [OUT_W-1:0]   core_out,
    input  logic               core_rdy,
    output logic               res_valid,
    output logic [IDX_W-1:0]   res_idx,
    output logic [OUT_W-1:0]   res_data,
    output logic               busy,
    output logic               layer_done,
    output logic               err
);

    localparam int              BIT_W    = clog2_min1(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(M-1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH-1);

    sched_state_t       state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [BIT_W-1:0]   bit_q;
    logic               core_start_q;
    logic               res_valid_q;
    logic [IDX_W-1:0]   res_idx_q;
    logic [OUT_W-1:0]   res_data_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;

    logic [N*WIDTH-1:0] in_lat_q;
    logic [N*WIDTH-1:0] w_mem [M];
    logic [N*WIDTH-1:0] w_sel;
    logic [N-1:0]       inp_bits;
    logic [N-1:0]       w_bits;
    logic               feed_en;
    logic               wd_fire;

`ifdef SERIAL_SCHED_TIMEOUT_EN
    localparam int WD_LIMIT = WDOG_MULT * WIDTH;
    localparam int WD_W     = clog2_min1(WD_LIMIT + 1);
    logic [WD_W-1:0] wd_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q <= '0;
        end else if (state_q == ST_WAIT) begin
            wd_q <= wd_q + 1'b1;
        end else begin
            wd_q <= '0;
        end
    end

    assign wd_fire = (state_q == ST_WAIT) && (wd_q == WD_W'(WD_LIMIT-1));
`else
    assign wd_fire = 1'b0;
`endif

    // Weight store and input latch carry data only; they are never reset.
    always_ff @(posedge clk) begin
        if (w_we && state_q == ST_IDLE && int'(w_addr) < M) begin
            w_mem[w_addr] <= w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (layer_start && state_q == ST_IDLE) begin
            in_lat_q <= in_vec;
        end
    end

    assign w_sel = w_mem[idx_q];

    serial_lane_feeder #(.N(N), .WIDTH(WIDTH)) u_inp_feeder (
        .clk         (clk),
        .rst         (rst),
        .load_i      (state_q == ST_LOAD),
        .shift_i     (state_q == ST_SHIFT),
        .hold_sign_i (state_q == ST_WAIT),
        .par_i       (in_lat_q),
        .bit_o       (inp_bits)
    );

    serial_lane_feeder #(.N(N), .WIDTH(WIDTH)) u_w_feeder (
        .clk         (clk),
        .rst         (rst),
        .load_i      (state_q == ST_LOAD),
        .shift_i     (state_q == ST_SHIFT),
        .hold_sign_i (state_q == ST_WAIT),
        .par_i       (w_sel),
        .bit_o       (w_bits)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            bit_q        <= '0;
            core_start_q <= 1'b0;
            res_valid_q  <= 1'b0;
            res_idx_q    <= '0;
            res_data_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            core_start_q <= 1'b0;
            res_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            // Any control traffic while a layer is in flight is dropped and flagged.
            if (state_q != ST_IDLE && (layer_start || w_we)) begin
                err_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (layer_start) begin
                        idx_q   <= '0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    bit_q        <= '0;
                    core_start_q <= 1'b1;
                    state_q      <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (bit_q == LAST_BIT) begin
                        state_q <= ST_WAIT;
                    end else begin
                        bit_q <= bit_q + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (core_rdy || wd_fire) begin
                        res_valid_q <= 1'b1;
                        res_idx_q   <= idx_q;
                        res_data_q  <= core_rdy ? core_out : '0;
                        if (!core_rdy) begin
                            err_q <= 1'b1;
                        end
                        if (idx_q == LAST_IDX) begin
                            state_q <= ST_DONE;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= ST_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign feed_en    = (state_q == ST_SHIFT) || (state_q == ST_WAIT);
    assign core_inp   = feed_en ? inp_bits : '0;
    assign core_w     = feed_en ? w_bits : '0;
    assign core_start = core_start_q;
    assign res_valid  = res_valid_q;
    assign res_idx    = res_idx_q;
    assign res_data   = res_data_q;
    assign busy       = busy_q;
    assign layer_done = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_serial_layer_scheduler.sv
// Directed bench for serial_layer_scheduler with a behavioural bit-serial core
// (latency 20) and a result scoreboard.
module tb_serial_layer_scheduler;

    localparam int N        = 2;
    localparam int M        = 4;
    localparam int WIDTH    = 8;
    localparam int OUT_W    = 8;
    localparam int IDX_W    = 2;
    localparam int CORE_LAT = 20;

    logic               clk = 1'b0;
    logic               rst;
    logic               w_we = 1'b0;
    logic [IDX_W-1:0]   w_addr = '0;
    logic [N*WIDTH-1:0] w_data = '0;
    logic               layer_start = 1'b0;
    logic [N*WIDTH-1:0] in_vec = '0;
    logic               core_start;
    logic [N-1:0]       core_inp;
    logic [N-1:0]       core_w;
    logic [OUT_W-1:0]   core_out;
    logic               core_rdy;
    logic               res_valid;
    logic [IDX_W-1:0]   res_idx;
    logic [OUT_W-1:0]   res_data;
    logic               busy;
    logic               layer_done;
    logic               err;

    serial_layer_scheduler #(
        .N(N), .M(M), .WIDTH(WIDTH), .OUT_W(OUT_W), .IDX_W(IDX_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .w_we        (w_we),
        .w_addr      (w_addr),
        .w_data      (w_data),
        .layer_start (layer_start),
        .in_vec      (in_vec),
        .core_start  (core_start),
        .core_inp    (core_inp),
        .core_w      (core_w),
        .core_out    (core_out),
        .core_rdy    (core_rdy),
        .res_valid   (res_valid),
        .res_idx     (res_idx),
        .res_data    (res_data),
        .busy        (busy),
        .layer_done  (layer_done),
        .err         (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int res_cnt = 0;
    int done_cnt = 0;
    int rv_cyc = -10;

    typedef struct {
        logic [IDX_W-1:0] idx;
        logic [OUT_W-1:0] data;
    } exp_t;
    exp_t sb[$];

    logic [N*WIDTH-1:0] wts [M];
    bit never_rdy = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [OUT_W-1:0] dot(input logic [N*WIDTH-1:0] a,
                                             input logic [N*WIDTH-1:0] b);
        int s;
        logic [WIDTH-1:0] la;
        logic [WIDTH-1:0] lb;
        s = 0;
        for (int k = 0; k < N; k++) begin
            la = a[k*WIDTH +: WIDTH];
            lb = b[k*WIDTH +: WIDTH];
            s += int'($signed(la)) * int'($signed(lb));
        end
        return s[OUT_W-1:0];
    endfunction

    always @(posedge clk) cyc++;

    // Behavioural core: deserialises WIDTH bits after core_start, answers CORE_LAT cycles later.
    logic [N*WIDTH-1:0] cm_in;
    logic [N*WIDTH-1:0] cm_w;
    int cm_ph = 0;
    bit cm_act = 1'b0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cm_act = 1'b0;
            core_rdy <= 1'b0;
            core_out <= '0;
        end else begin
            core_rdy <= 1'b0;
            if (core_start) begin
                cm_act = 1'b1;
                cm_ph  = 0;
            end
            if (cm_act) begin
                if (cm_ph < WIDTH) begin
                    for (int k = 0; k < N; k++) begin
                        cm_in[k*WIDTH + cm_ph] = core_inp[k];
                        cm_w[k*WIDTH + cm_ph]  = core_w[k];
                    end
                end
                if (cm_ph == CORE_LAT-1) begin
                    cm_act = 1'b0;
                    if (!never_rdy) begin
                        core_rdy <= 1'b1;
                        core_out <= dot(cm_in, cm_w);
                    end
                end
                cm_ph++;
            end
        end
    end

    // Result monitor / scoreboard consumer.
    always @(negedge clk) begin
        exp_t e;
        if (res_valid) begin
            res_cnt++;
            rv_cyc = cyc;
            check("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("res_idx", 32'(res_idx), 32'(e.idx));
                check("res_data", 32'(res_data), 32'(e.data));
            end
        end
        if (layer_done) begin
            done_cnt++;
            check("done_gap", cyc - rv_cyc, 1);
            check("busy_at_done", 32'(busy), 0);
        end
    end

    task automatic write_w(input logic [IDX_W-1:0] a, input logic [N*WIDTH-1:0] d);
        @(negedge clk);
        w_we = 1'b1; w_addr = a; w_data = d;
        wts[a] = d;
        @(negedge clk);
        w_we = 1'b0;
    endtask

    task automatic start_layer(input logic [N*WIDTH-1:0] v, input bit zero_res, input bit push);
        exp_t e;
        @(negedge clk);
        in_vec = v; layer_start = 1'b1;
        if (push) begin
            for (int n = 0; n < M; n++) begin
                e.idx  = IDX_W'(n);
                e.data = zero_res ? '0 : dot(v, wts[n]);
                sb.push_back(e);
            end
        end
        @(negedge clk);
        layer_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int start;
        int n;
        start = done_cnt; n = 0;
        while (done_cnt == start && n < budget) begin
            @(negedge clk); n++;
        end
        check(tag, 32'(done_cnt != start), 1);
    endtask

    task automatic wait_res(input int target, input int budget);
        int n;
        n = 0;
        while (res_cnt < target && n < budget) begin
            @(negedge clk); n++;
        end
        check("wait_res", 32'(res_cnt >= target), 1);
    endtask

    task automatic wait_start(input int budget);
        int n;
        n = 0;
        while (!core_start && n < budget) begin
            @(negedge clk); n++;
        end
        check("wait_core_start", 32'(core_start), 1);
    endtask

    function automatic logic [31:0] all_out();
        return 32'({core_start, core_inp, core_w, res_valid, res_idx, res_data,
                    busy, layer_done, err});
    endfunction

    initial begin
        int r0;
        logic [WIDTH-1:0] ina;
        logic [WIDTH-1:0] wa;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", all_out(), 0);
        rst = 1'b0;

        // Layer 1: basic sequencing of all four neurons.
        write_w(0, {8'h05, 8'h03});
        write_w(1, {8'hFE, 8'h07});
        write_w(2, {8'h11, 8'hF0});
        write_w(3, {8'h80, 8'h7F});
        r0 = res_cnt;
        start_layer({8'h10, 8'h20}, 1'b0, 1'b1);
        check("busy_running", 32'(busy), 1);
        wait_done("layer1_done", 300);
        check("layer1_count", res_cnt - r0, M);
        check("layer1_sb_empty", sb.size(), 0);
        @(negedge clk);
        check("layer1_busy_low", 32'(busy), 0);

        // Layer 2: serial bit order, weight written the cycle before start.
        write_w(0, {8'hC3, 8'h3C});
        start_layer({8'h7E, 8'hA5}, 1'b0, 1'b1);
        wait_start(10);
        ina = 8'hA5; wa = 8'h3C;
        for (int b = 0; b < WIDTH; b++) begin
            check("core_start_b", 32'(core_start), 32'(b == 0));
            check("core_inp0_bit", 32'(core_inp[0]), 32'(ina[b]));
            check("core_w0_bit", 32'(core_w[0]), 32'(wa[b]));
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            check("core_inp0_sign", 32'(core_inp[0]), 1);
            check("core_w0_sign", 32'(core_w[0]), 0);
            @(negedge clk);
        end
        wait_done("layer2_done", 300);

        // Layer 3: start and weight write while busy are dropped and flagged.
        r0 = res_cnt;
        start_layer({8'h81, 8'h33}, 1'b0, 1'b1);
        check("err_clear_l3", 32'(err), 0);
        wait_res(r0 + 2, 200);
        repeat (3) @(negedge clk);
        layer_start = 1'b1; in_vec = 16'hFFFF;
        w_we = 1'b1; w_addr = 2'd2; w_data = 16'h5A5A;
        @(negedge clk);
        layer_start = 1'b0; w_we = 1'b0;
        check("err_set", 32'(err), 1);
        check("busy_kept", 32'(busy), 1);
        wait_done("layer3_done", 300);
        check("layer3_count", res_cnt - r0, M);
        check("err_sticky", 32'(err), 1);

        // Layer 4: reset during SHIFT of neuron 1 aborts cleanly.
        r0 = res_cnt;
        start_layer({8'h0F, 8'hF1}, 1'b0, 1'b1);
        check("err_cleared", 32'(err), 0);
        wait_res(r0 + 1, 200);
        wait_start(10);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_outputs", all_out(), 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        r0 = res_cnt;
        begin
            int d0;
            d0 = done_cnt;
            repeat (40) @(negedge clk);
            check("abort_no_done", done_cnt - d0, 0);
            check("abort_no_res", res_cnt - r0, 0);
        end
        start_layer({8'h44, 8'hCC}, 1'b0, 1'b1);
        wait_done("layer5_done", 300);
        check("layer5_count", res_cnt - r0, M);

        // Layer 6: core never answers.
        never_rdy = 1'b1;
        r0 = res_cnt;
`ifdef SERIAL_SCHED_TIMEOUT_EN
        start_layer({8'h12, 8'h34}, 1'b1, 1'b1);
        wait_done("timeout_done", 600);
        check("timeout_count", res_cnt - r0, M);
        check("timeout_err", 32'(err), 1);
`else
        start_layer({8'h12, 8'h34}, 1'b0, 1'b0);
        repeat (150) @(negedge clk);
        check("hang_busy", 32'(busy), 1);
        check("hang_no_res", res_cnt - r0, 0);
        check("hang_err", 32'(err), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`endif
        never_rdy = 1'b0;
        r0 = res_cnt;
        start_layer({8'h55, 8'h9C}, 1'b0, 1'b1);
        wait_done("layer7_done", 300);
        check("layer7_count", res_cnt - r0, M);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
